mem_bus_controller: RTL
=======================

MEM_BUS_CONTROLLER -- requirements
Module: mem_bus_controller

Interface
REQ-001 SHALL have parameter N_SLV, default 4: number of slave regions, 1..8.
REQ-002 SHALL have parameter DATA_W, default 32: data width, a multiple of 8.
REQ-003 SHALL have parameter ADDR_W, default 32: address width.
REQ-004 SHALL have parameter TIMEOUT, default 15: ACCESS cycles without ack before error, 1..255.
REQ-005 SHALL have parameter SLV_BASE, default {0x1002_0000, 0x1001_0000, 0x0040_0000, 0x0}: packed N_SLV*ADDR_W region base addresses, slave 0 in the LSBs.
REQ-006 SHALL have parameter SLV_MASK, default {0xFFFF_FF00, 0xFFFF_0000, 0xFFC0_0000, 0x0}: packed region masks; a mask of 0 disables that region.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port bus_req, input, 1 bit: master access request.
REQ-010 SHALL have port bus_addr, input, ADDR_W bits: byte address.
REQ-011 SHALL have port bus_wrdata, input, DATA_W bits: write data.
REQ-012 SHALL have port bus_wren, input, 1 bit: 1 = write, 0 = read.
REQ-013 SHALL have port bus_be, input, DATA_W/8 bits: byte enables.
REQ-014 SHALL have port bus_ready, output, 1 bit: one-cycle response strobe.
REQ-015 SHALL have port bus_rddata, output, DATA_W bits: registered read data.
REQ-016 SHALL have port bus_err, output, 1 bit: error, valid with bus_ready.
REQ-017 SHALL have port slv_sel, output, N_SLV bits: one-hot slave select.
REQ-018 SHALL have port slv_addr, output, ADDR_W bits: word offset, (addr - base) >> 2.
REQ-019 SHALL have port slv_wrdata, output, DATA_W bits: latched write data.
REQ-020 SHALL have port slv_be, output, DATA_W/8 bits: latched byte enables.
REQ-021 SHALL have port slv_wren, output, N_SLV bits: per-slave write enable.
REQ-022 SHALL have port slv_rddata, input, N_SLV*DATA_W bits: packed slave read data.
REQ-023 SHALL have port slv_ack, input, N_SLV bits: per-slave completion.
REQ-024 SHALL have port err_count, output, 8 bits: saturating error counter.

Function
REQ-025 SHALL decode a hit on slave i when (bus_addr & SLV_MASK[i]) == SLV_BASE[i] and SLV_MASK[i] != 0; on overlap, the lowest index wins.
REQ-026 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-027 IDLE with bus_req=1 and a hit SHALL latch addr, wrdata, be, wren and the index, then go to ACCESS.
REQ-028 IDLE with bus_req=1 and no hit SHALL go to RESP with error set.
REQ-029 ACCESS SHALL drive slv_sel[i]=1 and slv_wren[i]=latched wren, with all other slv_sel/slv_wren bits 0, and SHALL increment a wait counter each cycle.
REQ-030 ACCESS with slv_ack[i]=1 SHALL capture slice i of slv_rddata into the bus_rddata register (reads only) and go to RESP with error clear.
REQ-031 ACCESS with the wait counter == TIMEOUT and no ack SHALL go to RESP with error set.
REQ-032 Ack and timeout in the same cycle SHALL resolve in favour of ack.
REQ-033 Acks from unselected slaves SHALL be ignored.
REQ-034 RESP SHALL assert bus_ready=1 for exactly one cycle, with bus_err equal to the error flag, then return to IDLE.
REQ-035 On error, bus_rddata SHALL be 0.
REQ-036 Writes SHALL leave bus_rddata unchanged.
REQ-037 Minimum latency SHALL be: request sampled in cycle 0, ack in cycle 1, bus_ready in cycle 2.
REQ-038 An unmapped access SHALL see bus_ready in cycle 1.
REQ-039 bus_req and the bus inputs SHALL be ignored outside IDLE; back-to-back requests are accepted in the cycle after RESP.
REQ-040 err_count SHALL increment on every RESP with error and saturate at 255.
REQ-041 slv_addr SHALL be computed as (latched addr - SLV_BASE[idx]) >> 2, modulo 2^ADDR_W.
REQ-042 slv_addr, slv_wrdata and slv_be SHALL be held stable throughout ACCESS.

Reset
REQ-043 rst=0 SHALL immediately force: state IDLE, bus_ready=0, bus_err=0, bus_rddata=0, slv_sel=0, slv_wren=0, slv_addr=0, slv_wrdata=0, slv_be=0, err_count=0, wait counter=0.
REQ-044 Reset asserted mid-ACCESS SHALL abort the transfer with no response generated.
REQ-045 After reset deassertion, the block SHALL accept a request on the first clock edge.

Verification
REQ-046 Read of 0x0040_0008 with slave1 acking in cycle 1 and data 0xDEAD_BEEF SHALL give slv_sel=0b0010, slv_addr=2, and bus_ready=1 with bus_rddata=0xDEAD_BEEF in cycle 2.
REQ-047 Write of 0x1001_0010, data 0x1234_5678, be=0xF, with ack after 3 wait cycles SHALL hold slv_wren[2]=1 and slv_addr=4 for 4 cycles, then give bus_ready=1, bus_err=0.
REQ-048 Read of 0x2000_0000 (unmapped) SHALL give bus_ready=1, bus_err=1, bus_rddata=0 in cycle 1, and err_count=1.
REQ-049 Read of 0x1002_0004 with no ack SHALL give bus_err=1 after TIMEOUT=15 ACCESS cycles; 300 such errors SHALL leave err_count=255.
REQ-050 Reset pulsed low during ACCESS with slave3 SHALL deassert all outputs immediately, and a fresh request 1 cycle later SHALL complete normally.
REQ-051 Simultaneous slv_ack=0b1111 while slave1 is selected SHALL return slice 1 only, and ack with counter==TIMEOUT SHALL give bus_err=0.

Source files
------------

// File: rtl/mem_bus_controller.sv
// Single-master bus decoder/controller: address decode, per-slave select, ack/timeout handling.
// Latency: 2 cycles minimum (mapped), 1 cycle (unmapped); requests are accepted only in IDLE.
module mem_bus_controller #(
  parameter int N_SLV   = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {32'h1002_0000, 32'h1001_0000, 32'h0040_0000, 32'h0000_0000},
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFC0_0000, 32'h0000_0000}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bus_req,
  input  logic [ADDR_W-1:0]       bus_addr,
  input  logic [DATA_W-1:0]       bus_wrdata,
  input  logic                    bus_wren,
  input  logic [DATA_W/8-1:0]     bus_be,
  output logic                    bus_ready,
  output logic [DATA_W-1:0]       bus_rddata,
  output logic                    bus_err,
  output logic [N_SLV-1:0]        slv_sel,
  output logic [ADDR_W-1:0]       slv_addr,
  output logic [DATA_W-1:0]       slv_wrdata,
  output logic [DATA_W/8-1:0]     slv_be,
  output logic [N_SLV-1:0]        slv_wren,
  input  logic [N_SLV*DATA_W-1:0] slv_rddata,
  input  logic [N_SLV-1:0]        slv_ack,
  output logic [7:0]              err_count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wren_q, wren_d;
  logic               err_q, err_d;
  logic [7:0]         wait_q, wait_d;
  logic [DATA_W-1:0]  rddata_q, rddata_d;
  logic [ADDR_W-1:0]  slv_addr_q, slv_addr_d;
  logic [DATA_W-1:0]  wrdata_q, wrdata_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [7:0]         err_count_q, err_count_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [ADDR_W-1:0]  hit_base;
  logic               sel_ack;
  logic [DATA_W-1:0]  sel_rd;
  logic [N_SLV-1:0]   sel_oh;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((SLV_MASK[i*ADDR_W +: ADDR_W] != '0) &&
          ((bus_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_base = SLV_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign sel_ack = slv_ack[idx_q];
  assign sel_rd  = slv_rddata[int'(idx_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wren_d      = wren_q;
    err_d       = err_q;
    wait_d      = wait_q;
    rddata_d    = rddata_q;
    slv_addr_d  = slv_addr_q;
    wrdata_d    = wrdata_q;
    be_d        = be_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (bus_req) begin
          if (hit) begin
            idx_d      = hit_idx;
            wren_d     = bus_wren;
            err_d      = 1'b0;
            wait_d     = 8'd0;
            slv_addr_d = (bus_addr - hit_base) >> 2;
            wrdata_d   = bus_wrdata;
            be_d       = bus_be;
            state_d    = ACCESS;
          end else begin
            err_d    = 1'b1;
            rddata_d = '0;
            state_d  = RESP;
          end
        end
      end
      ACCESS: begin
        // Ack is tested first so a last-cycle ack still completes cleanly.
        if (sel_ack) begin
          err_d = 1'b0;
          if (!wren_q) rddata_d = sel_rd;
          state_d = RESP;
        end else if (wait_q == 8'(TIMEOUT)) begin
          err_d    = 1'b1;
          rddata_d = '0;
          state_d  = RESP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RESP: begin
        if (err_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wren_q      <= 1'b0;
      err_q       <= 1'b0;
      wait_q      <= 8'd0;
      rddata_q    <= '0;
      slv_addr_q  <= '0;
      wrdata_q    <= '0;
      be_q        <= '0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wren_q      <= wren_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
      rddata_q    <= rddata_d;
      slv_addr_q  <= slv_addr_d;
      wrdata_q    <= wrdata_d;
      be_q        <= be_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    sel_oh = '0;
    if (state_q == ACCESS) sel_oh[idx_q] = 1'b1;
  end

  assign bus_ready  = (state_q == RESP);
  assign bus_err    = bus_ready & err_q;
  assign bus_rddata = rddata_q;
  assign slv_sel    = sel_oh;
  assign slv_wren   = wren_q ? sel_oh : '0;
  assign slv_addr   = slv_addr_q;
  assign slv_wrdata = wrdata_q;
  assign slv_be     = be_q;
  assign err_count  = err_count_q;

endmodule
